// File: rtl/nicnac_pkg.sv
//------------------------------------------------------------------------------
// nicnac_pkg
// Shared types and constants for the NICNAC16 major-state sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nicnac_pkg;

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DEFER   = 2'd2,
        ST_EXECUTE = 2'd3
    } major_state_e;

    localparam logic [3:0] c_sta_op    = 4'h3;
    localparam int         c_mri_limit = 8;

    localparam int c_ph_t0 = 0;
    localparam int c_ph_t1 = 1;

endpackage

`default_nettype wire

// File: rtl/nicnac_phase_counter.sv
//------------------------------------------------------------------------------
// nicnac_phase_counter
// Wrapping phase counter with one-hot decode, enable, sync clear, last flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nicnac_phase_counter
    import nicnac_pkg::*;
#(
    parameter int N_PHASES = 4,
    parameter int PHASE_W  = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_clr,
    output logic [PHASE_W-1:0]  o_phase,
    output logic [N_PHASES-1:0] o_onehot,
    output logic                o_last
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    assign o_last  = (phase_q == PHASE_W'(N_PHASES - 1));
    assign o_phase = phase_q;

    always_comb begin
        phase_d = phase_q;
        if (i_clr) begin
            phase_d = PHASE_W'(c_ph_t0);
        end else if (i_en) begin
            phase_d = o_last ? PHASE_W'(c_ph_t0) : phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PHASE_W'(c_ph_t0);
        end else begin
            phase_q <= phase_d;
        end
    end

    // Decode is gated so no phase pulse escapes while the sequencer is idle.
    for (genvar i = 0; i < N_PHASES; i++) begin : g_decode
        assign o_onehot[i] = i_en && (phase_q == PHASE_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/nicnac_sequencer.sv
//------------------------------------------------------------------------------
// nicnac_sequencer
// Major-state / timing-pulse sequencer with run/halt and memory-write control.
// Optional macro: NICNAC_SEQ_SINGLE_STEP_EN (single-step via SS_MODE/STEP).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nicnac_sequencer
    import nicnac_pkg::*;
#(
    parameter int                N_PHASES  = 4,
    parameter int                OPCODE_W  = 4,
    parameter logic [OPCODE_W-1:0] STA_OP  = OPCODE_W'(c_sta_op),
    parameter int                MRI_LIMIT = c_mri_limit
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                RUN,
    input  logic                HALT_REQ,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic                IND,
    input  logic                SS_MODE,
    input  logic                STEP,
    output logic [N_PHASES-1:0] T,
    output logic                FETCH,
    output logic                DEFER,
    output logic                EXECUTE,
    output logic                I_STA,
    output logic                SETWRITE,
    output logic                CLRWRITE,
    output logic                WRITE,
    output logic                HALTED,
    output logic [OPCODE_W-1:0] IR_OP
);

    localparam int c_pw = $clog2(N_PHASES);

    if (N_PHASES < 3) begin : g_bad_n_phases
        $fatal(1, "nicnac_sequencer: N_PHASES must be at least 3");
    end

    major_state_e        state_q, state_d;
    logic [OPCODE_W-1:0] ir_op_q, ir_op_d;
    logic                ind_q, ind_d;
    logic                write_q, write_d;

    logic                w_running;
    logic                w_last;
    logic                w_ph1;
    logic [c_pw-1:0]     w_phase;
    logic                w_is_mri;
    logic                w_halt_eff;
    logic                w_run_eff;

`ifdef NICNAC_SEQ_SINGLE_STEP_EN
    assign w_halt_eff = HALT_REQ | SS_MODE;
    assign w_run_eff  = RUN | STEP;
`else
    logic w_unused_ss;
    assign w_halt_eff  = HALT_REQ;
    assign w_run_eff   = RUN;
    assign w_unused_ss = ^{SS_MODE, STEP};
`endif

    assign w_running = (state_q != ST_HALTED);

    nicnac_phase_counter #(
        .N_PHASES (N_PHASES),
        .PHASE_W  (c_pw)
    ) u_phase (
        .clk      (CLK),
        .rst      (RESET),
        .i_en     (w_running),
        .i_clr    (~w_running),
        .o_phase  (w_phase),
        .o_onehot (T),
        .o_last   (w_last)
    );

    assign w_ph1    = (w_phase == c_pw'(c_ph_t1));
    assign w_is_mri = (int'(ir_op_q) < MRI_LIMIT);

    // Halt is only taken where the next state would otherwise be FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALTED: begin
                if (w_run_eff) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_last) begin
                    if (w_is_mri)        state_d = ind_q ? ST_DEFER : ST_EXECUTE;
                    else if (w_halt_eff) state_d = ST_HALTED;
                    else                 state_d = ST_FETCH;
                end
            end
            ST_DEFER: begin
                if (w_last) state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (w_last) state_d = w_halt_eff ? ST_HALTED : ST_FETCH;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    always_comb begin
        ir_op_d = ir_op_q;
        ind_d   = ind_q;
        if (state_q == ST_FETCH && w_ph1) begin
            ir_op_d = OPCODE;
            ind_d   = IND;
        end
    end

    assign SETWRITE = (state_q == ST_EXECUTE) && w_ph1 && I_STA;
    assign CLRWRITE = (state_q == ST_EXECUTE) && w_last && write_q;

    always_comb begin
        write_d = write_q;
        if (state_q != ST_EXECUTE) write_d = 1'b0;
        else if (SETWRITE)         write_d = 1'b1;
        else if (CLRWRITE)         write_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_HALTED;
            ir_op_q <= '0;
            ind_q   <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_op_q <= ir_op_d;
            ind_q   <= ind_d;
            write_q <= write_d;
        end
    end

    assign HALTED  = (state_q == ST_HALTED);
    assign FETCH   = (state_q == ST_FETCH);
    assign DEFER   = (state_q == ST_DEFER);
    assign EXECUTE = (state_q == ST_EXECUTE);
    assign I_STA   = (ir_op_q == STA_OP);
    assign WRITE   = write_q;
    assign IR_OP   = ir_op_q;

endmodule

`default_nettype wire
